// File: rtl/ram_sync_be_pkg.sv
// Shared definitions for the byte-enable synchronous RAM.
// Combinational constants and helpers only; no latency.
// No flow control of its own.
package ram_sync_be_pkg;

  // Read-during-write behaviour selector values
  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Controller states: zero-fill sweep, then normal operation
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Pointer width for a given depth, never narrower than one bit
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_sync_be_if.sv
// Request/response bundle between the MEM stage and the data RAM.
// Pure wiring; no latency.
// busy from the RAM tells the requester that requests are being dropped.
interface ram_sync_be_if #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 64
);
  localparam int BYTES = WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [WIDTH-1:0]      in;
  logic                  write;
  logic [BYTES-1:0]      byte_en;
  logic                  read;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic                  busy;
  logic                  addr_err;

  // Requester side
  modport master (
    output address, in, write, byte_en, read,
    input  out, out_valid, busy, addr_err
  );

  // RAM side
  modport slave (
    input  address, in, write, byte_en, read,
    output out, out_valid, busy, addr_err
  );
endinterface

// File: rtl/ram_sync_be_byte_merge.sv
// Byte-lane merge: lanes with enable set take the new word, others keep the old.
// Purely combinational, zero latency.
// No backpressure.
module byte_merge #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   old_word,
  input  logic [WIDTH-1:0]   new_word,
  input  logic [WIDTH/8-1:0] lanes,
  output logic [WIDTH-1:0]   merged
);
  localparam int BYTES = WIDTH / 8;

  // Select each byte independently from the new or the old word
  always_comb begin
    merged = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (lanes[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/ram_sync_be.sv
// Single-port data RAM with byte enables, range checking and optional zero-fill after reset.
// Read data and out_valid appear one cycle after the request; addr_err likewise.
// No stall in READY; while busy (zero-fill sweep) all requests are silently dropped.
module ram_sync_be
  import ram_sync_be_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 64,
  parameter int READ_MODE      = READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clock,
  input logic          reset,
  ram_sync_be_if.slave bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [PW-1:0]         LAST    = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    ptr;
  logic             busy;

  logic             addr_ok;
  logic [PW-1:0]    idx;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged;
  logic             wr_en;

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             addr_err_q;

  // Range check uses the full address width so high bits never alias into the array
  assign addr_ok  = (bus.address < DEPTH_A);
  assign idx      = bus.address[PW-1:0];
  assign old_word = mem[idx];
  assign wr_en    = !reset && !busy && bus.write && addr_ok;

  // Shared merge feeds both the memory write and the write-first read bypass
  byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_word (old_word),
    .new_word (bus.in),
    .lanes    (bus.byte_en),
    .merged   (merged)
  );

  // State register: reset re-enters the sweep from the start when clearing is enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave the sweep after the last word has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (ptr == LAST) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  // State outputs: busy for the whole sweep
  always_comb begin
    busy = (state == ST_CLEAR);
  end

  // Sweep pointer walks the array once per clear
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (busy) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Memory array: zero-fill during the sweep, byte-merged write otherwise; reset leaves contents alone
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) begin
        mem[ptr] <= '0;
      end else if (wr_en) begin
        mem[idx] <= merged;
      end
    end
  end

  // Registered read port and error flag; out holds when there is no read
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else if (busy) begin
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.read;
      addr_err_q  <= (bus.read || bus.write) && !addr_ok;
      if (bus.read) begin
        if (!addr_ok) begin
          out_q <= '0;
        end else if (READ_MODE == WRITE_FIRST && bus.write) begin
          out_q <= merged;
        end else begin
          out_q <= old_word;
        end
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_ram_sync_be.sv
// Bench for ram_sync_be: one read-first and one write-first instance driven identically,
// compared against an array-based model of the RAM's documented behaviour.
module tb_ram_sync_be;
  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_sync_be_if #(.WIDTH(64), .ADDR_WIDTH(64)) bus0 ();
  ram_sync_be_if #(.WIDTH(64), .ADDR_WIDTH(64)) bus1 ();

  ram_sync_be #(.WIDTH(64), .DEPTH(256), .ADDR_WIDTH(64), .READ_MODE(0), .CLEAR_ON_RESET(1))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  ram_sync_be #(.WIDTH(64), .DEPTH(256), .ADDR_WIDTH(64), .READ_MODE(1), .CLEAR_ON_RESET(1))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;

  // Reference state
  logic [63:0] model [256];
  logic [63:0] exp_out0;
  logic [63:0] exp_out1;
  logic        exp_valid;
  logic        exp_err;

  task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic w,
                       input logic [7:0] be, input logic r);
    bus0.address = a; bus0.in = d; bus0.write = w; bus0.byte_en = be; bus0.read = r;
    bus1.address = a; bus1.in = d; bus1.write = w; bus1.byte_en = be; bus1.read = r;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  // One ready-state request: predict results, then advance one clock
  task automatic apply(input logic [63:0] a, input logic [63:0] d, input logic w,
                       input logic [7:0] be, input logic r);
    logic        ok;
    logic [63:0] old;
    logic [63:0] mrg;
    ok  = (a < 64'd256);
    old = ok ? model[a[7:0]] : 64'd0;
    for (int l = 0; l < 8; l++) mrg[8*l +: 8] = be[l] ? d[8*l +: 8] : old[8*l +: 8];
    if (r) begin
      exp_out0 = ok ? old : 64'd0;
      exp_out1 = ok ? (w ? mrg : old) : 64'd0;
    end
    exp_valid = r;
    exp_err   = (r || w) && !ok;
    if (w && ok) model[a[7:0]] = mrg;
    drive(a, d, w, be, r);
    tick();
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    drive(64'd0, 64'd0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 1", bus0.busy, bus1.busy);
    end
    n_checks++;
    if (bus0.out !== 64'd0 || bus1.out !== 64'd0 || bus0.out_valid !== 1'b0 || bus0.addr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: out=%h/%h valid=%b err=%b want 0", bus0.out, bus1.out, bus0.out_valid, bus0.addr_err);
    end
    // Requests during the sweep must be ignored
    drive(64'd3, '1, 1'b1, 8'hFF, 1'b1);
    cnt = 0;
    while (bus0.busy === 1'b1 && cnt < 600) begin
      n_checks++;
      if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus0.addr_err !== 1'b0) begin
        n_fail++; $display("FAIL sweep_quiet: valid=%b/%b err=%b want 0", bus0.out_valid, bus1.out_valid, bus0.addr_err);
      end
      cnt++;
      tick();
    end
    drive(64'd0, 64'd0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (cnt != 256 || bus1.busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_len: busy cycles=%0d dut1 busy=%b want 256/0", cnt, bus1.busy);
    end
    model_zero();
    exp_out0 = '0; exp_out1 = '0;
    for (int i = 0; i < 256; i++) begin
      apply(64'(i), 64'd0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus0.out_valid !== 1'b1 || bus1.out_valid !== 1'b1 || bus0.out !== 64'd0 || bus1.out !== 64'd0) begin
        n_fail++; $display("FAIL clear_read[%0d]: out=%h/%h valid=%b/%b want 0/1", i, bus0.out, bus1.out, bus0.out_valid, bus1.out_valid);
      end
    end
  endtask

  task automatic test_full_write();
    apply(64'd5, 64'hDEADBEEF_CAFEF00D, 1'b1, 8'hFF, 1'b0);
    n_checks++;
    if (bus0.out_valid !== 1'b0 || bus0.addr_err !== 1'b0) begin
      n_fail++; $display("FAIL write_flags: valid=%b err=%b want 0/0", bus0.out_valid, bus0.addr_err);
    end
    apply(64'd5, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'hDEADBEEF_CAFEF00D || bus1.out !== 64'hDEADBEEF_CAFEF00D || bus0.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_write: out=%h/%h valid=%b want deadbeefcafef00d/1", bus0.out, bus1.out, bus0.out_valid);
    end
  endtask

  task automatic test_byte_lanes();
    apply(64'd5, 64'h11111111_22222222, 1'b1, 8'h0F, 1'b0);
    apply(64'd5, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'hDEADBEEF_22222222 || bus1.out !== 64'hDEADBEEF_22222222) begin
      n_fail++; $display("FAIL byte_lanes: out=%h/%h want deadbeef22222222", bus0.out, bus1.out);
    end
    // Write with no lanes enabled changes nothing
    apply(64'd5, '1, 1'b1, 8'h00, 1'b0);
    apply(64'd5, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'hDEADBEEF_22222222 || bus0.addr_err !== 1'b0) begin
      n_fail++; $display("FAIL be_zero_noop: out=%h err=%b want deadbeef22222222/0", bus0.out, bus0.addr_err);
    end
  endtask

  task automatic test_rw_same_addr();
    apply(64'd7, 64'hA5, 1'b1, 8'hFF, 1'b1);
    n_checks++;
    if (bus0.out !== 64'd0 || bus0.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rw_read_first: out=%h valid=%b want 0/1", bus0.out, bus0.out_valid);
    end
    n_checks++;
    if (bus1.out !== 64'hA5 || bus1.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rw_write_first: out=%h valid=%b want a5/1", bus1.out, bus1.out_valid);
    end
    apply(64'd7, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'hA5 || bus1.out !== 64'hA5) begin
      n_fail++; $display("FAIL rw_followup: out=%h/%h want a5", bus0.out, bus1.out);
    end
    apply(64'd0, 64'd0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (bus0.out !== 64'hA5 || bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL out_hold: out=%h valid=%b/%b want a5/0", bus0.out, bus0.out_valid, bus1.out_valid);
    end
  endtask

  task automatic test_out_of_range();
    apply(64'd256, '1, 1'b1, 8'hFF, 1'b0);
    n_checks++;
    if (bus0.addr_err !== 1'b1 || bus1.addr_err !== 1'b1 || bus0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL oor_write: err=%b/%b valid=%b want 1/0", bus0.addr_err, bus1.addr_err, bus0.out_valid);
    end
    // High address bit set: would alias word 5 if truncated
    apply(64'h8000_0000_0000_0005, '1, 1'b1, 8'hFF, 1'b0);
    n_checks++;
    if (bus0.addr_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_high_write: err=%b want 1", bus0.addr_err);
    end
    apply(64'd256, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'd0 || bus1.out !== 64'd0 || bus0.out_valid !== 1'b1 || bus0.addr_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_read: out=%h/%h valid=%b err=%b want 0/1/1", bus0.out, bus1.out, bus0.out_valid, bus0.addr_err);
    end
    apply(64'd5, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'hDEADBEEF_22222222 || bus0.addr_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_no_alias: out=%h err=%b want deadbeef22222222/0", bus0.out, bus0.addr_err);
    end
    apply(64'd0, 64'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus0.out !== 64'd0 || bus1.out !== 64'd0) begin
      n_fail++; $display("FAIL oor_word0: out=%h/%h want 0", bus0.out, bus1.out);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [63:0] a;
    logic [63:0] d;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} | 64'h100 : 64'(256 + $urandom_range(0, 50));
      else a = 64'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      apply(a, d, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      n_checks++;
      if (bus0.out !== exp_out0 || bus1.out !== exp_out1 || bus0.out_valid !== exp_valid ||
          bus1.out_valid !== exp_valid || bus0.addr_err !== exp_err || bus1.addr_err !== exp_err || bus0.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%h/%h valid=%b/%b err=%b/%b busy=%b want out=%h/%h valid=%b err=%b busy=0",
                 n, bus0.out, bus1.out, bus0.out_valid, bus1.out_valid, bus0.addr_err, bus1.addr_err, bus0.busy,
                 exp_out0, exp_out1, exp_valid, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    reset = 1'b1;
    drive(64'd9, '1, 1'b1, 8'hFF, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (bus0.busy !== 1'b1) begin
        n_fail++; $display("FAIL mid_busy[%0d]: busy=%b want 1", i, bus0.busy);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus0.out !== 64'd0 || bus1.out !== 64'd0 || bus0.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: out=%h/%h busy=%b want 0/1", bus0.out, bus1.out, bus0.busy);
    end
    cnt = 0;
    while (bus0.busy === 1'b1 && cnt < 600) begin
      cnt++;
      tick();
    end
    drive(64'd0, 64'd0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (cnt != 256) begin
      n_fail++; $display("FAIL mid_sweep_len: busy cycles=%0d want 256", cnt);
    end
    model_zero();
    exp_out0 = '0; exp_out1 = '0;
    for (int i = 0; i < 256; i++) begin
      apply(64'(i), 64'd0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus0.out !== 64'd0 || bus1.out !== 64'd0 || bus0.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL mid_clear[%0d]: out=%h/%h valid=%b want 0/1", i, bus0.out, bus1.out, bus0.out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_rw_same_addr();
    test_out_of_range();
    test_back_to_back_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
